rewire_serial_driver: RTL and testbench

//  Drives a 1-bit-in / 1-bit-out generated stream device and presents it as a word interface.
//  - Serializes W-bit words from a valid/ready source onto the device input bit (LSB first).
//  - Captures the device output bit each shift cycle and returns the W-bit response word on a

---
 rtl/rewire_serial_driver.sv | 144 ++++++++++++++
 tb/tb_rewire_serial_driver.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rewire_serial_driver.sv
// Word-to-bit-serial driver for a 1-in/1-out generated stream device, LSB first, response captured per shift cycle.
// Optional even-parity trailer cycle and m_par output when REWIRE_SERIAL_DRIVER_PARITY_EN is defined.
module rewire_serial_driver #(
   parameter int unsigned W        = 8,
   parameter int unsigned GAP      = 0,
   parameter logic        IDLE_BIT = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [W-1:0] s_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic [W-1:0] m_data,
   output logic         dut_in,
   input  logic         dut_out,
   output logic         busy
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
   ,
   output logic         m_par
`endif
);

`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
   localparam int unsigned LAST = W;
`else
   localparam int unsigned LAST = W - 1;
`endif
   localparam int unsigned CW = $clog2(LAST + 2);
   localparam int unsigned GW = $clog2(GAP + 2);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, WAIT} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  data_q, data_d;
   logic [W-1:0]  rsp_q, rsp_d;
   logic [W-1:0]  m_data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          dut_in_d, m_valid_d, next_bit;
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
   logic          m_par_d;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         rsp_q   <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         dut_in  <= IDLE_BIT;
         m_valid <= 1'b0;
         m_data  <= '0;
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
         m_par   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rsp_q   <= rsp_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         dut_in  <= dut_in_d;
         m_valid <= m_valid_d;
         m_data  <= m_data_d;
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
         m_par   <= m_par_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      rsp_d     = rsp_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      dut_in_d  = dut_in;
      m_valid_d = m_valid;
      m_data_d  = m_data;
      s_ready   = 1'b0;
      next_bit  = IDLE_BIT;
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
      m_par_d   = m_par;
`endif
      for (int k = 1; k < int'(W); k++)
         if (cnt_q == CW'(k - 1)) next_bit = data_q[k];

      case (state_q)
         IDLE: s_ready = 1'b1;
         SHIFT: begin
            for (int k = 0; k < int'(W); k++)
               if (cnt_q == CW'(k)) rsp_d[k] = dut_out;
            if (cnt_q == CW'(LAST)) begin
               // Final bit goes out with the response so m_data includes it.
               m_valid_d = 1'b1;
               m_data_d  = rsp_d;
               dut_in_d  = IDLE_BIT;
               state_d   = HOLD;
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
               m_par_d   = dut_out;
            end else if (cnt_q == CW'(W - 1)) begin
               dut_in_d  = ^data_q;
               cnt_d     = cnt_q + CW'(1);
`endif
            end else begin
               dut_in_d  = next_bit;
               cnt_d     = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (GAP == 0) begin
                  s_ready = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
                  gap_d   = GW'(GAP);
               end
            end
         end
         WAIT: begin
            if (gap_q == GW'(1)) state_d = IDLE;
            else                 gap_d   = gap_q - GW'(1);
         end
         default: state_d = IDLE;
      endcase

      // Accept from IDLE, or straight out of HOLD when no gap is configured.
      if (s_valid && s_ready) begin
         data_d    = s_data;
         dut_in_d  = s_data[0];
         cnt_d     = '0;
         m_valid_d = 1'b0;
         state_d   = SHIFT;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rewire_serial_driver.sv
// Directed bench: one driver with GAP=0 (loopback/invert device) and one with GAP=3 (loopback).
module tb_rewire_serial_driver;

`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 8;
`endif

   logic       clk, rst;
   logic       s_valid0, s_ready0, m_valid0, m_ready0, dut_in0, dut_out0, busy0, m_par0, inv0;
   logic [7:0] s_data0, m_data0;
   logic       s_valid3, s_ready3, m_valid3, m_ready3, dut_in3, dut_out3, busy3, m_par3;
   logic [7:0] s_data3, m_data3;
   int         nchk, nerr;

   assign dut_out0 = inv0 ? ~dut_in0 : dut_in0;
   assign dut_out3 = dut_in3;

   rewire_serial_driver #(.W(8), .GAP(0), .IDLE_BIT(1'b0)) u0 (
      .clk(clk), .rst(rst), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data0),
      .m_valid(m_valid0), .m_ready(m_ready0), .m_data(m_data0),
      .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0)
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
      , .m_par(m_par0)
`endif
   );

   rewire_serial_driver #(.W(8), .GAP(3), .IDLE_BIT(1'b0)) u3 (
      .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3),
      .m_valid(m_valid3), .m_ready(m_ready3), .m_data(m_data3),
      .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3)
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
      , .m_par(m_par3)
`endif
   );

`ifndef REWIRE_SERIAL_DRIVER_PARITY_EN
   assign m_par0 = 1'b0;
   assign m_par3 = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         inv;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input bit inv, input logic [7:0] d, input logic [7:0] exp);
      logic [7:0] obs;
      bit         early;
      inv0     = inv;
      s_data0  = d;
      s_valid0 = 1'b1;
      m_ready0 = 1'b1;
      chk("accept_ready", s_ready0, 1);
      tick;
      s_valid0 = 1'b0;
      s_data0  = ~d;
      obs   = '0;
      early = 1'b0;
      for (int k = 0; k < 8; k++) begin
         obs[k] = dut_in0;
         if (m_valid0 !== 1'b0) early = 1'b1;
         tick;
      end
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
      chk("parity_bit", dut_in0, ^d);
      if (m_valid0 !== 1'b0) early = 1'b1;
      tick;
      chk("m_par", m_par0, inv ? ~(^d) : ^d);
`endif
      chk("bit_stream", obs, d);
      chk("early_valid", early, 0);
      chk("m_valid_latency", m_valid0, 1);
      chk("m_data", m_data0, exp);
      chk("idle_after_word", dut_in0, 0);
      tick;
      chk("m_valid_drop", m_valid0, 0);
      chk("back_to_idle", {s_ready0, busy0}, 2'b10);
   endtask

   initial begin
      logic [7:0] obs;
      bit         bad;
      int         n;
      nchk = 0;
      nerr = 0;
      vecs[0] = '{1'b0, 8'hA5, 8'hA5};
      vecs[1] = '{1'b1, 8'h00, 8'hFF};
      vecs[2] = '{1'b1, 8'h3C, 8'hC3};
      vecs[3] = '{1'b0, 8'h81, 8'h81};
      vecs[4] = '{1'b1, 8'hFF, 8'h00};
      vecs[5] = '{1'b0, 8'h5A, 8'h5A};

      rst = 1'b0; inv0 = 1'b0;
      s_valid0 = 1'b0; s_data0 = '0; m_ready0 = 1'b1;
      s_valid3 = 1'b0; s_data3 = '0; m_ready3 = 1'b1;
      #22;
      chk("rst_dut_in", {dut_in0, dut_in3}, 2'b00);
      chk("rst_m_valid", {m_valid0, m_valid3}, 2'b00);
      chk("rst_m_data", {m_data0, m_data3}, 16'h0000);
      chk("rst_s_ready", {s_ready0, s_ready3}, 2'b11);
      chk("rst_busy", {busy0, busy3}, 2'b00);
      chk("rst_m_par", {m_par0, m_par3}, 2'b00);
      @(negedge clk);
      rst = 1'b1;
      tick;

      for (int i = 0; i < 6; i++) run_word(vecs[i].inv, vecs[i].din, vecs[i].exp);

      // Back-to-back words through HOLD with GAP=0; s_data changes while shifting are ignored.
      inv0 = 1'b1; m_ready0 = 1'b1;
      s_data0 = 8'h00; s_valid0 = 1'b1;
      tick;
      s_data0 = 8'h3C;
      repeat (LAT - 1) tick;
      chk("b2b_no_early_valid", m_valid0, 0);
      tick;
      chk("b2b_first_valid", m_valid0, 1);
      chk("b2b_first_data", m_data0, 8'hFF);
      chk("b2b_hold_s_ready", s_ready0, 1);
      tick;
      s_valid0 = 1'b0;
      chk("b2b_second_start", {m_valid0, busy0}, 2'b01);
      obs = '0;
      for (int k = 0; k < 8; k++) begin
         obs[k] = dut_in0;
         tick;
      end
      repeat (LAT - 8) tick;
      chk("b2b_second_bits", obs, 8'h3C);
      chk("b2b_second_valid", m_valid0, 1);
      chk("b2b_second_data", m_data0, 8'hC3);
      tick;

      // Response held under backpressure.
      inv0 = 1'b0; m_ready0 = 1'b0;
      s_data0 = 8'hA5; s_valid0 = 1'b1;
      tick;
      s_valid0 = 1'b0;
      repeat (LAT) tick;
      chk("bp_valid", m_valid0, 1);
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (m_valid0 !== 1'b1 || m_data0 !== 8'hA5 || s_ready0 !== 1'b0) bad = 1'b1;
         tick;
      end
      chk("bp_stable", bad, 0);
      m_ready0 = 1'b1;
      #1;
      chk("bp_ready_passthru", s_ready0, 1);
      tick;
      chk("bp_after_xfer", {m_valid0, s_ready0}, 2'b01);

      // Reset in the middle of a word.
      s_data0 = 8'hFF; s_valid0 = 1'b1;
      tick;
      s_valid0 = 1'b0;
      repeat (4) tick;
      chk("mid_word_bit", {dut_in0, busy0}, 2'b11);
      rst = 1'b0;
      #1;
      chk("mid_rst_outputs", {dut_in0, m_valid0, busy0, s_ready0}, 4'b0001);
      chk("mid_rst_m_data", m_data0, 8'h00);
      @(negedge clk);
      rst = 1'b1;
      tick;
      run_word(1'b0, 8'h81, 8'h81);
`ifdef REWIRE_SERIAL_DRIVER_PARITY_EN
      run_word(1'b0, 8'h07, 8'h07);
`endif

      // GAP=3: two queued words, forced idle between them.
      m_ready3 = 1'b1;
      s_data3 = 8'h5A; s_valid3 = 1'b1;
      tick;
      s_data3 = 8'hC3;
      repeat (LAT) tick;
      chk("gap_first_valid", m_valid3, 1);
      chk("gap_first_data", m_data3, 8'h5A);
      chk("gap_hold_s_ready", s_ready3, 0);
      tick;
      n = 0;
      bad = 1'b0;
      while (s_ready3 !== 1'b1 && n < 20) begin
         if (busy3 !== 1'b1 || dut_in3 !== 1'b0) bad = 1'b1;
         n++;
         tick;
      end
      chk("gap_wait_cycles", n, 3);
      chk("gap_idle_busy", bad, 0);
      tick;
      s_valid3 = 1'b0;
      chk("gap_second_first_bit", {dut_in3, busy3}, 2'b11);
      repeat (LAT) tick;
      chk("gap_second_valid", m_valid3, 1);
      chk("gap_second_data", m_data3, 8'hC3);
      tick;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
